// File: rtl/fsc_pkg.sv
// Shared definitions for the XOR parity frame checker/recoverer.
package fsc_pkg;

    localparam int unsigned W_DEF     = 4;
    localparam int unsigned LANES_DEF = 6;

    // Index width for a lane count; never narrower than one bit.
    function automatic int unsigned IDX_W(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic {
        ACC,
        RESULT
    } state_t;

    // Erasure count encoding (saturates at NERA_MULTI).
    localparam logic [1:0] NERA_NONE  = 2'd0;
    localparam logic [1:0] NERA_ONE   = 2'd1;
    localparam logic [1:0] NERA_MULTI = 2'd2;

endpackage

// File: rtl/xor_parity_recover.sv
// Streaming XOR parity decoder: accumulates one frame of LANES nibbles,
// then reports the syndrome, rebuilds a single erased lane, or flags
// an unrecoverable multi-erasure frame. Result is held until accepted.
module xor_parity_recover
    import fsc_pkg::*;
#(
    parameter int unsigned W     = W_DEF,
    parameter int unsigned LANES = LANES_DEF
) (
    input  logic                        iclk,
    input  logic                        irst,
    input  logic                        ivld,
    output logic                        ordy,
    input  logic [W-1:0]                idat,
    input  logic                        iera,
    output logic                        ovld,
    input  logic                        irdy,
    output logic [W-1:0]                oq,
    output logic [IDX_W(LANES)-1:0]     oidx,
    output logic                        ook,
    output logic                        oerr
);

    localparam int unsigned IW = IDX_W(LANES);
    localparam logic [IW-1:0] LAST = IW'(LANES - 1);

    state_t          state_q, state_d;
    logic [IW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [1:0]      nera_q, nera_d;
    logic [IW-1:0]   eidx_q, eidx_d;
    logic [W-1:0]    oq_q, oq_d;
    logic [IW-1:0]   oidx_q, oidx_d;
    logic            ook_q, ook_d;
    logic            oerr_q, oerr_d;

    // Beat-updated tracker values, valid whenever a beat is presented.
    logic [W-1:0]    beat_acc;
    logic [1:0]      beat_nera;
    logic [IW-1:0]   beat_eidx;

    // Ready only while accumulating; held low during reset.
    always_comb begin
        ordy = (state_q == ACC) && !irst;
        ovld = (state_q == RESULT);
        oq   = oq_q;
        oidx = oidx_q;
        ook  = ook_q;
        oerr = oerr_q;
    end

    // Accumulator and erasure tracker as they would be after this beat.
    always_comb begin
        beat_acc  = acc_q ^ (iera ? '0 : idat);
        beat_nera = nera_q;
        beat_eidx = eidx_q;
        if (iera) begin
            if (nera_q == NERA_NONE) begin
                beat_eidx = cnt_q;
            end
            if (nera_q != NERA_MULTI) begin
                beat_nera = nera_q + 2'd1;
            end
        end
    end

    // Next-state: accept beats in ACC, latch result on the final beat, release on irdy.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        nera_d  = nera_q;
        eidx_d  = eidx_q;
        oq_d    = oq_q;
        oidx_d  = oidx_q;
        ook_d   = ook_q;
        oerr_d  = oerr_q;
        unique case (state_q)
            ACC: begin
                if (ivld && ordy) begin
                    acc_d  = beat_acc;
                    nera_d = beat_nera;
                    eidx_d = beat_eidx;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = RESULT;
                        unique case (beat_nera)
                            NERA_NONE: begin
                                oq_d   = beat_acc;
                                oidx_d = '0;
                                ook_d  = (beat_acc == '0);
                                oerr_d = 1'b0;
                            end
                            NERA_ONE: begin
                                oq_d   = beat_acc;
                                oidx_d = beat_eidx;
                                ook_d  = 1'b1;
                                oerr_d = 1'b0;
                            end
                            default: begin
                                oq_d   = '0;
                                oidx_d = beat_eidx;
                                ook_d  = 1'b0;
                                oerr_d = 1'b1;
                            end
                        endcase
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            RESULT: begin
                if (irdy) begin
                    state_d = ACC;
                    acc_d   = '0;
                    nera_d  = NERA_NONE;
                    eidx_d  = '0;
                end
            end
        endcase
    end

    // State register; reset discards any partial frame.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state_q <= ACC;
            cnt_q   <= '0;
            acc_q   <= '0;
            nera_q  <= NERA_NONE;
            eidx_q  <= '0;
            oq_q    <= '0;
            oidx_q  <= '0;
            ook_q   <= 1'b0;
            oerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            nera_q  <= nera_d;
            eidx_q  <= eidx_d;
            oq_q    <= oq_d;
            oidx_q  <= oidx_d;
            ook_q   <= ook_d;
            oerr_q  <= oerr_d;
        end
    end

endmodule

// File: tb/tb_xor_parity_recover.sv
// Self-checking bench: directed vector table, random frames against a
// behavioural model, plus backpressure and mid-frame reset sequences.
module tb_xor_parity_recover;

    localparam int W     = 4;
    localparam int LANES = 6;
    localparam int IW    = 3;

    logic          iclk = 1'b0;
    logic          irst = 1'b1;
    logic          ivld = 1'b0;
    logic          ordy;
    logic [W-1:0]  idat = '0;
    logic          iera = 1'b0;
    logic          ovld;
    logic          irdy = 1'b0;
    logic [W-1:0]  oq;
    logic [IW-1:0] oidx;
    logic          ook;
    logic          oerr;

    int checks = 0;
    int errors = 0;

    xor_parity_recover #(.W(W), .LANES(LANES)) dut (
        .iclk (iclk),
        .irst (irst),
        .ivld (ivld),
        .ordy (ordy),
        .idat (idat),
        .iera (iera),
        .ovld (ovld),
        .irdy (irdy),
        .oq   (oq),
        .oidx (oidx),
        .ook  (ook),
        .oerr (oerr)
    );

    always #5 iclk = ~iclk;

    typedef struct {
        logic [W-1:0]     dat [LANES];
        logic [LANES-1:0] era;
        logic [W-1:0]     e_q;
        logic [IW-1:0]    e_idx;
        logic             e_ok;
        logic             e_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: XOR of surviving lanes, erasure count and first erased index.
    task automatic model(input vec_t v, output logic [W-1:0] q, output logic [IW-1:0] idx,
                         output logic ok, output logic err);
        int n = 0;
        int first = 0;
        logic [W-1:0] x = '0;
        for (int i = 0; i < LANES; i++) begin
            if (v.era[i]) begin
                if (n == 0) first = i;
                n++;
            end else begin
                x = x ^ v.dat[i];
            end
        end
        if (n == 0) begin
            q = x; idx = '0; ok = (x == 0); err = 1'b0;
        end else if (n == 1) begin
            q = x; idx = IW'(first); ok = 1'b1; err = 1'b0;
        end else begin
            q = '0; idx = IW'(first); ok = 1'b0; err = 1'b1;
        end
    endtask

    // Push a frame; after the last beat ovld must be high one cycle later.
    task automatic send_frame(input vec_t v, input string name);
        for (int i = 0; i < LANES; i++) begin
            int guard = 0;
            ivld = 1'b1;
            idat = v.dat[i];
            iera = v.era[i];
            while (!ordy && guard < 20) begin
                @(posedge iclk); #1;
                guard++;
            end
            if (!ordy) begin
                chk({name, " ordy timeout"}, 32'(ordy), 32'd1);
                ivld = 1'b0;
                return;
            end
            @(posedge iclk); #1;
            if (i < LANES - 1) chk({name, " ovld early"}, 32'(ovld), 32'd0);
        end
        ivld = 1'b0;
        iera = 1'b0;
        chk({name, " latency ovld"}, 32'(ovld), 32'd1);
        chk({name, " ordy in result"}, 32'(ordy), 32'd0);
    endtask

    task automatic check_result(input vec_t v, input string name);
        chk({name, " oq"}, 32'(oq), 32'(v.e_q));
        chk({name, " oidx"}, 32'(oidx), 32'(v.e_idx));
        chk({name, " ook"}, 32'(ook), 32'(v.e_ok));
        chk({name, " oerr"}, 32'(oerr), 32'(v.e_err));
    endtask

    task automatic accept(input string name);
        irdy = 1'b1;
        @(posedge iclk); #1;
        irdy = 1'b0;
        chk({name, " ovld cleared"}, 32'(ovld), 32'd0);
        chk({name, " ordy back"}, 32'(ordy), 32'd1);
    endtask

    function automatic vec_t mk(input logic [23:0] d, input logic [LANES-1:0] era,
                                input logic [W-1:0] q, input logic [IW-1:0] idx,
                                input logic ok, input logic err);
        vec_t v;
        // d holds lane 0 in its top nibble
        for (int i = 0; i < LANES; i++) v.dat[i] = d[(LANES-1-i)*W +: W];
        v.era = era; v.e_q = q; v.e_idx = idx; v.e_ok = ok; v.e_err = err;
        return v;
    endfunction

    vec_t tbl [7];
    vec_t rv;
    vec_t clean;

    initial begin
        tbl[0] = mk(24'h35ACFF, 6'b000000, 4'h0, 3'd0, 1'b1, 1'b0); // clean
        tbl[1] = mk(24'h350CFF, 6'b000100, 4'hA, 3'd2, 1'b1, 1'b0); // lane 2 erased
        tbl[2] = mk(24'h35ACEF, 6'b000000, 4'h1, 3'd0, 1'b0, 1'b0); // lane 4 corrupt
        tbl[3] = mk(24'h30A0FF, 6'b001010, 4'h0, 3'd1, 1'b0, 1'b1); // lanes 1,3 erased
        tbl[4] = mk(24'h35ACF0, 6'b100000, 4'hF, 3'd5, 1'b1, 1'b0); // last lane erased
        tbl[5] = mk(24'h05ACFF, 6'b000001, 4'h3, 3'd0, 1'b1, 1'b0); // lane 0 erased
        tbl[6] = mk(24'h050C0F, 6'b010101, 4'h0, 3'd0, 1'b0, 1'b1); // saturating count
        clean  = tbl[0];

        // Reset state
        #2;
        chk("reset ovld", 32'(ovld), 32'd0);
        chk("reset oq", 32'(oq), 32'd0);
        chk("reset oidx", 32'(oidx), 32'd0);
        chk("reset ook", 32'(ook), 32'd0);
        chk("reset oerr", 32'(oerr), 32'd0);
        @(posedge iclk); #1;
        irst = 1'b0;
        #1;
        chk("ordy after reset", 32'(ordy), 32'd1);

        // Directed table
        for (int t = 0; t < 7; t++) begin
            string nm;
            nm = $sformatf("vec%0d", t);
            send_frame(tbl[t], nm);
            check_result(tbl[t], nm);
            accept(nm);
        end

        // Backpressure: ivld held high while the result waits
        send_frame(tbl[1], "bp");
        ivld = 1'b1; idat = 4'h3; iera = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge iclk); #1;
            chk("bp ovld held", 32'(ovld), 32'd1);
            chk("bp ordy low", 32'(ordy), 32'd0);
            check_result(tbl[1], "bp hold");
        end
        accept("bp");
        send_frame(clean, "bp next");
        check_result(clean, "bp next");
        accept("bp next");

        // Mid-frame reset discards partial state
        for (int i = 0; i < 3; i++) begin
            ivld = 1'b1; idat = 4'h9; iera = (i == 1);
            @(posedge iclk); #1;
        end
        ivld = 1'b0; iera = 1'b0;
        irst = 1'b1; #3;
        chk("midrst ovld", 32'(ovld), 32'd0);
        irst = 1'b0;
        @(posedge iclk); #1;
        send_frame(clean, "post rst");
        check_result(clean, "post rst");
        accept("post rst");

        // Random frames against the model; erased lanes carry junk data
        for (int f = 0; f < 40; f++) begin
            string nm;
            for (int i = 0; i < LANES; i++) begin
                rv.dat[i] = W'($urandom);
                rv.era[i] = ($urandom_range(0, 5) == 0);
            end
            model(rv, rv.e_q, rv.e_idx, rv.e_ok, rv.e_err);
            nm = $sformatf("rnd%0d", f);
            send_frame(rv, nm);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) @(posedge iclk);
                #1;
            end
            check_result(rv, nm);
            accept(nm);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/xor_parity_recover.md
Name: xor_parity_recover

Overview:
- Streaming decoder/checker for the 6-lane XOR parity encoding produced by the combinational nibble-XOR block: 5 data lanes plus 1 parity lane.
- Accepts one frame of LANES nibbles serially over a valid/ready handshake. Each beat may be flagged erased.
- At end of frame, reconstructs a single erased lane or reports the parity syndrome, then holds the result until downstream accepts it.
- Sits on the receive side, after the lane deserialiser.

Parameters:
- W, 4, nibble/lane width in bits.
- LANES, 6, beats per frame: data lanes plus the parity lane. Legal range 2..16.

Ports:
- iclk  input  1  clock; all state updates on the rising edge.
- irst  input  1  asynchronous, active-high reset.
- ivld  input  1  input beat valid.
- ordy  output  1  block can accept an input beat.
- idat  input  W  lane value; ignored when iera=1.
- iera  input  1  this beat's lane is erased/missing.
- ovld  output  1  result valid.
- irdy  input  1  downstream accepts the result.
- oq  output  W  reconstructed lane value, or syndrome (see Behaviour).
- oidx  output  clog2(LANES)  index of the erased lane.
- ook  output  1  frame consistent or recovered.
- oerr  output  1  unrecoverable: two or more erasures.

Behaviour:
- Reset (async, irst=1): state=ACC, cnt=0, acc=0, nera=0, eidx=0. Outputs: ovld=0, oq=0, oidx=0, ook=0, oerr=0, ordy=1 once irst is released.
- A reset mid-frame discards the partial frame; the next accepted beat is lane 0.
- Input handshake: a beat is accepted when ivld&&ordy.
- ordy=1 only in ACC; ordy=0 in RESULT.
- ACC, beat accepted:
  - acc ^= (iera ? 0 : idat).
  - If iera: nera saturates at 2; eidx captures cnt on the first erasure only.
  - cnt increments.
- Final beat (cnt==LANES-1, accepted):
  - Result fields are computed from the beat-updated values and registered.
  - cnt returns to 0; state moves to RESULT.
  - ovld=1 on the next cycle (latency 1 cycle after the last beat).
- Result encoding:
  - nera=0: oq=syndrome (acc); ook=(syndrome==0); oerr=0; oidx=0.
  - nera=1: oq=acc (reconstructed lane); oidx=eidx; ook=1; oerr=0.
  - nera=2: oq=0; oidx=first erased index; ook=0; oerr=1.
- RESULT state:
  - oq, oidx, ook and oerr are held stable while ovld=1 && irdy=0.
  - On ovld&&irdy: ovld=0, acc=0, nera=0, state=ACC. ordy=1 from the following cycle.
- Throughput: LANES+1 cycles per frame minimum.
- Beats offered while ordy=0 are not consumed; upstream must hold them.
- Width rules: all XOR is W bits, no carries. cnt and eidx are clog2(LANES) bits; cnt never exceeds LANES-1 (no wrap beyond it). nera is 2 bits, saturating.
- Simultaneous irst and a handshake: reset wins.

Decomposition:
- Shared package fsc_pkg holds:
  - W_DEF=4, LANES_DEF=6;
  - IDX_W function (clog2);
  - state enum {ACC, RESULT};
  - result-encoding constants NERA_NONE, NERA_ONE, NERA_MULTI.
- Single module, no sub-module. The accumulator/erasure tracker is under 40 lines and not reused.

Test Plan:
- Frame 3,5,A,C,F,F, no erasures -> ovld one cycle after the last beat; oq=0, ook=1, oerr=0, oidx=0.
- Same frame, lane 2 erased (idat=0, iera=1) -> oq=A, oidx=2, ook=1, oerr=0.
- Lane 4 corrupted (3,5,A,C,E,F), no erasures -> oq=1, ook=0, oerr=0.
- Lanes 1 and 3 erased -> oerr=1, ook=0, oq=0, oidx=1.
- Backpressure: irdy=0 for 3 cycles after ovld, ivld held at 1 -> outputs stable, ordy=0, no beat consumed. After irdy, the next frame decodes correctly.
- irst pulsed after 3 beats of a frame, then a clean frame 3,5,A,C,F,F -> ook=1, oq=0. Confirms partial-frame state is discarded.
